uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter comm_clk_frequency, default 50_000_000, clk frequency in Hz.
REQ-002 SHALL have parameter baud_rate, default 115_200, serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, received-byte buffer entries (power of two, >=2).
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port uart_rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 SHALL have port rx_byte  output  8  byte at FIFO head.
REQ-008 SHALL have port rx_valid  output  1  high while FIFO non-empty.
REQ-009 SHALL have port rx_ready  input  1  consumer accepts rx_byte when rx_valid & rx_ready.
REQ-010 SHALL have port framing_error  output  1  one-cycle pulse on bad stop bit.
REQ-011 SHALL have port overflow  output  1  sticky flag, byte dropped due to full FIFO.

Function
REQ-012 SHALL define DIV = round(comm_clk_frequency / baud_rate), with DIV >= 4.
REQ-013 SHALL pass uart_rx through a 2-flop synchronizer (reset value 1); all decoding uses the synchronized value rxs.
REQ-014 SHALL implement states IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-015 IDLE: on rxs falling (previous 1, current 0) SHALL load bit counter with DIV/2-1 and enter START.
REQ-016 Bit counter SHALL count down one per clk; a "sample point" is the cycle the counter equals 0.
REQ-017 START sample point: rxs=0 -> reload DIV-1, bit index 0, enter DATA; rxs=1 -> glitch, return IDLE, nothing reported.
REQ-018 DATA sample point: shift rxs into bit[index], LSB first; reload DIV-1; after index 7 enter STOP, else index+1.
REQ-019 STOP sample point: rxs=1 -> push byte into FIFO, enter IDLE; rxs=0 -> pulse framing_error, discard byte, enter WAIT_IDLE.
REQ-020 WAIT_IDLE SHALL return to IDLE on first cycle rxs=1; no start detection while in WAIT_IDLE.
REQ-021 Pushed byte SHALL appear on rx_byte with rx_valid=1 the cycle after the stop-bit sample point (if FIFO was empty).
REQ-022 Pop SHALL occur on any cycle with rx_valid & rx_ready; rx_byte shows the next entry the following cycle.
REQ-023 Pop when empty SHALL be ignored; rx_byte holds last value.
REQ-024 Push when full with no pop in the same cycle SHALL drop the new byte, keep FIFO contents, set overflow.
REQ-025 Simultaneous push and pop when full SHALL both occur; no overflow.
REQ-026 Simultaneous push and pop when empty SHALL leave the pushed byte stored (count 1).
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH; bytes SHALL leave in arrival order.
REQ-028 overflow SHALL stay high until reset.

Reset
REQ-029 reset SHALL force state IDLE, counters 0, FIFO empty, synchronizer flops 1.
REQ-030 During and after reset: rx_valid=0, rx_byte=8'h00, framing_error=0, overflow=0.
REQ-031 reset mid-frame SHALL abandon the frame; bits already on the line before reset release SHALL not produce a byte; line low at release SHALL not trigger START until a 1->0 edge is seen.

Verification (bench uses comm_clk_frequency=16, baud_rate=1 -> DIV=16)
REQ-032 Send 0xA5 with valid stop, rx_ready=1 -> rx_valid one cycle, rx_byte=0xA5, framing_error=0, overflow=0.
REQ-033 Send 0x3C with stop bit 0, hold line low 40 cycles, then high, then send 0x55 -> one framing_error pulse, no 0x3C delivered, 0x55 delivered.
REQ-034 Pulse uart_rx low 4 cycles from idle -> no rx_valid, no framing_error, FSM back in IDLE; following 0x81 received correctly.
REQ-035 rx_ready=0, send 0x01..0x05 -> overflow=1 after fifth stop bit; drain yields 0x01,0x02,0x03,0x04 then rx_valid=0.
REQ-036 Assert reset at DATA bit 3 of a frame, release, send 0xF0 -> first byte lost, outputs at reset values, 0xF0 received.
REQ-037 Ten back-to-back frames 0x00..0x09 (no idle gap) with rx_ready=1 -> all ten received in order, no errors.

Source files
------------

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with mid-bit sampling and a small receive-byte FIFO.
// A byte is visible one cycle after its stop-bit sample; when the FIFO is full, incoming bytes are dropped and overflow is set.
module uart_receiver #(
    parameter int comm_clk_frequency = 50_000_000,
    parameter int baud_rate          = 115_200,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       framing_error,
    output logic       overflow
);

    localparam int DIV = (comm_clk_frequency + baud_rate / 2) / baud_rate;
    localparam int CW  = $clog2(DIV);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] C_HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] C_FULL = CW'(DIV - 1);
    localparam logic [PW:0]   C_DEPTH = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_sync1;
    logic            r_sync2;
    logic [1:0]      r_warm;
    logic            r_prev;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_idx;
    logic [7:0]      r_shift;
    logic            r_framing_error;
    logic            r_overflow;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW:0]     r_count;
    logic [7:0]      r_hold;

    logic w_rxs;
    logic w_fall;
    logic w_tick;
    logic w_load_half;
    logic w_load_full;
    logic w_shift_en;
    logic w_push;
    logic w_ferr;
    logic w_pop;
    logic w_full;
    logic w_wr;

    assign w_rxs  = r_sync2;
    assign w_fall = r_prev & ~w_rxs;
    assign w_tick = (r_cnt == '0);

    // r_warm keeps edge detection blind until the synchronizer holds real line samples,
    // so a line already low at reset release cannot look like a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_warm  <= 2'b00;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= uart_rx;
            r_sync2 <= r_sync1;
            r_warm  <= {r_warm[0], 1'b1};
            r_prev  <= r_sync2 & r_warm[1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (w_fall) w_state_nxt = S_START;
            S_START:     if (w_tick) w_state_nxt = w_rxs ? S_IDLE : S_DATA;
            S_DATA:      if (w_tick && r_idx == 3'd7) w_state_nxt = S_STOP;
            S_STOP:      if (w_tick) w_state_nxt = w_rxs ? S_IDLE : S_WAIT_IDLE;
            S_WAIT_IDLE: if (w_rxs) w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_load_half = 1'b0;
        w_load_full = 1'b0;
        w_shift_en  = 1'b0;
        w_push      = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            S_IDLE:  w_load_half = w_fall;
            S_START: w_load_full = w_tick & ~w_rxs;
            S_DATA: begin
                w_shift_en  = w_tick;
                w_load_full = w_tick;
            end
            S_STOP: begin
                w_push = w_tick & w_rxs;
                w_ferr = w_tick & ~w_rxs;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
        end else begin
            if (w_load_half)
                r_cnt <= C_HALF;
            else if (w_load_full)
                r_cnt <= C_FULL;
            else if (r_state != S_IDLE && r_state != S_WAIT_IDLE && !w_tick)
                r_cnt <= r_cnt - CW'(1);

            if (r_state == S_START && w_load_full)
                r_idx <= 3'd0;
            else if (w_shift_en) begin
                r_shift[r_idx] <= w_rxs;
                r_idx          <= r_idx + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_framing_error <= 1'b0;
        else       r_framing_error <= w_ferr;
    end

    assign w_pop  = rx_valid & rx_ready;
    assign w_full = (r_count == C_DEPTH);
    assign w_wr   = w_push & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= r_shift;
    end

    // r_hold keeps the last delivered byte on rx_byte once the FIFO runs empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_hold     <= 8'h00;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
                r_hold   <= r_mem[r_rd_ptr];
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + (PW + 1)'(1);
                2'b01:   r_count <= r_count - (PW + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    assign rx_valid      = (r_count != '0);
    assign rx_byte       = rx_valid ? r_mem[r_rd_ptr] : r_hold;
    assign framing_error = r_framing_error;
    assign overflow      = r_overflow;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit: table of single frames plus hand-written corner sequences.
module tb_uart_receiver;

    localparam int BIT = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       uart_rx;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ready;
    logic       framing_error;
    logic       overflow;

    always #5 clk = ~clk;

    uart_receiver #(
        .comm_clk_frequency(16),
        .baud_rate         (1),
        .FIFO_DEPTH        (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .uart_rx      (uart_rx),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .framing_error(framing_error),
        .overflow     (overflow)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] log_q [0:255];
    int n_rx   = 0;
    int n_vld  = 0;
    int n_ferr = 0;

    always @(negedge clk) begin
        if (rx_valid && rx_ready) begin
            log_q[n_rx[7:0]] <= rx_byte;
            n_rx <= n_rx + 1;
        end
        if (rx_valid)      n_vld  <= n_vld + 1;
        if (framing_error) n_ferr <= n_ferr + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        uart_rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        drive(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive(b[i], BIT);
        drive(stop, BIT);
    endtask

    typedef struct {
        logic [7:0] in_byte;
        logic       in_stop;
        int         exp_cnt;
        logic [7:0] exp_byte;
        int         exp_ferr;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int b_rx, b_vld, b_fe;

        vecs[0] = '{8'hA5, 1'b1, 1, 8'hA5, 0};
        vecs[1] = '{8'h00, 1'b1, 1, 8'h00, 0};
        vecs[2] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
        vecs[3] = '{8'h3C, 1'b0, 0, 8'h00, 1};
        vecs[4] = '{8'h55, 1'b1, 1, 8'h55, 0};
        vecs[5] = '{8'h96, 1'b1, 1, 8'h96, 0};

        reset    = 1'b1;
        uart_rx  = 1'b1;
        rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", rx_valid, 0);
        chk("rst_byte", rx_byte, 8'h00);
        chk("rst_ferr", framing_error, 0);
        chk("rst_ovf", overflow, 0);
        reset = 1'b0;
        drive(1'b1, 20);

        for (int i = 0; i < 6; i++) begin
            b_rx = n_rx; b_vld = n_vld; b_fe = n_ferr;
            send(vecs[i].in_byte, vecs[i].in_stop);
            if (!vecs[i].in_stop) drive(1'b0, 40);
            drive(1'b1, 20);
            chk($sformatf("vec%0d_count", i), n_rx - b_rx, vecs[i].exp_cnt);
            chk($sformatf("vec%0d_vld_cycles", i), n_vld - b_vld, vecs[i].exp_cnt);
            chk($sformatf("vec%0d_ferr", i), n_ferr - b_fe, vecs[i].exp_ferr);
            if (vecs[i].exp_cnt > 0) chk($sformatf("vec%0d_byte", i), log_q[b_rx], vecs[i].exp_byte);
            chk($sformatf("vec%0d_ovf", i), overflow, 0);
        end

        // Short low glitch from idle must be rejected, then a normal frame follows.
        b_rx = n_rx; b_fe = n_ferr;
        drive(1'b0, 4);
        drive(1'b1, 40);
        chk("glitch_count", n_rx - b_rx, 0);
        chk("glitch_ferr", n_ferr - b_fe, 0);
        send(8'h81, 1'b1);
        drive(1'b1, 20);
        chk("post_glitch_count", n_rx - b_rx, 1);
        chk("post_glitch_byte", log_q[b_rx], 8'h81);

        b_rx = n_rx; b_fe = n_ferr;
        for (int k = 0; k < 10; k++) send(k[7:0], 1'b1);
        drive(1'b1, 20);
        chk("b2b_count", n_rx - b_rx, 10);
        chk("b2b_ferr", n_ferr - b_fe, 0);
        for (int k = 0; k < 10; k++) chk($sformatf("b2b_byte%0d", k), log_q[b_rx + k], k);

        rx_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            send(k[7:0], 1'b1);
            drive(1'b1, 4);
            if (k == 4) chk("ovf_before_fifth", overflow, 0);
            if (k == 5) chk("ovf_after_fifth", overflow, 1);
        end
        chk("full_valid", rx_valid, 1);
        chk("full_head", rx_byte, 8'h01);
        b_rx = n_rx;
        rx_ready = 1'b1;
        drive(1'b1, 10);
        chk("drain_count", n_rx - b_rx, 4);
        for (int k = 0; k < 4; k++) chk($sformatf("drain_byte%0d", k), log_q[b_rx + k], k + 1);
        chk("drain_valid", rx_valid, 0);
        chk("drain_hold", rx_byte, 8'h04);
        chk("ovf_sticky", overflow, 1);

        // Reset lands in data bit 3 of a frame while the line is low.
        drive(1'b0, BIT);
        drive(1'b0, 3 * BIT);
        drive(1'b0, 8);
        reset = 1'b1;
        drive(1'b0, 3);
        chk("midrst_valid", rx_valid, 0);
        chk("midrst_byte", rx_byte, 8'h00);
        chk("midrst_ferr", framing_error, 0);
        chk("midrst_ovf", overflow, 0);
        reset = 1'b0;
        b_rx = n_rx; b_fe = n_ferr;
        drive(1'b0, 40);
        chk("rel_low_count", n_rx - b_rx, 0);
        chk("rel_low_valid", rx_valid, 0);
        chk("rel_low_ferr", n_ferr - b_fe, 0);
        drive(1'b1, 20);
        send(8'hF0, 1'b1);
        drive(1'b1, 20);
        chk("after_rst_count", n_rx - b_rx, 1);
        chk("after_rst_byte", log_q[b_rx], 8'hF0);
        chk("after_rst_ferr", n_ferr - b_fe, 0);
        chk("after_rst_ovf", overflow, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
